mac_dot_seq_ctrl: RTL and testbench

// Sequencer for one posit dot-product lane: accepts K operand pairs over a valid/ready handshake and drives the MAC enable and clear.

---
 rtl/posit_mac_pkg.sv | 18 +
 rtl/mac_dot_seq_ctrl_vld_delay_line.sv | 23 ++
 rtl/mac_dot_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_mac_dot_seq_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_mac_pkg.sv
// Shared constants for the posit dot-product MAC lane controller.
// State encodings and default pipeline geometry.
package posit_mac_pkg;

    localparam int K_DEF        = 9;
    localparam int MUL_LAT_DEF  = 5;
    localparam int NORM_CYC_DEF = 3;
    localparam int VLD_W_DEF    = 12;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] S_ACCUM = 3'd1;
    localparam logic [ST_W-1:0] S_DRAIN = 3'd2;
    localparam logic [ST_W-1:0] S_NORM  = 3'd3;
    localparam logic [ST_W-1:0] S_OUT   = 3'd4;

endpackage

// File: rtl/mac_dot_seq_ctrl_vld_delay_line.sv
// Term-valid shift register tracking accepted terms through the MAC.
// Bit i is high when a term was accepted i+1 cycles ago.
module vld_delay_line #(
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         rstn,
    input  logic         clr,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else begin
            q <= {q[W-2:0], din};
        end
    end

endmodule

// File: rtl/mac_dot_seq_ctrl.sv
// Sequencer for one posit dot-product lane: operand intake, MAC drain,
// extraction-stage enable and result handshake.
module mac_dot_seq_ctrl
    import posit_mac_pkg::*;
#(
    parameter int K        = K_DEF,
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int NORM_CYC = NORM_CYC_DEF,
    parameter int VLD_W    = VLD_W_DEF,
    parameter int CNT_W    = $clog2(K + 1)
) (
    input  logic             clk_i,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             out_rdy,
    output logic             mac_en,
    output logic             acc_clr,
    output logic [VLD_W-1:0] vld_d,
    output logic             acc_rdy,
    output logic             out_vld,
    output logic             busy,
    output logic [CNT_W-1:0] term_cnt
);

    localparam int DW = $clog2(MUL_LAT + 1);
    localparam int NW = $clog2(NORM_CYC + 1);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nx;
    logic [DW-1:0]   drain_cnt;
    logic [NW-1:0]   norm_cnt;
    logic            last_term;

    assign last_term = mac_en && (term_cnt == CNT_W'(K - 1));

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (mac_en) state_nx = last_term ? S_DRAIN : S_ACCUM;
                end
                S_ACCUM: begin
                    if (last_term) state_nx = S_DRAIN;
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) state_nx = S_NORM;
                end
                S_NORM: begin
                    if (norm_cnt == '0) state_nx = S_OUT;
                end
                S_OUT: begin
                    if (out_rdy) state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_rdy  = 1'b0;
        mac_en  = 1'b0;
        acc_clr = 1'b0;
        acc_rdy = 1'b0;
        out_vld = 1'b0;
        busy    = 1'b0;
        in_rdy  = (state == S_IDLE) || (state == S_ACCUM);
        mac_en  = in_vld && in_rdy && !flush;
        acc_clr = mac_en && (term_cnt == '0);
        acc_rdy = (state == S_NORM);
        out_vld = (state == S_OUT);
        busy    = (state != S_IDLE);
    end

    // Phase counters are loaded on the cycle the FSM enters the phase.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            term_cnt  <= '0;
            drain_cnt <= '0;
            norm_cnt  <= '0;
        end else if (flush) begin
            term_cnt  <= '0;
            drain_cnt <= '0;
            norm_cnt  <= '0;
        end else begin
            if (state == S_OUT && out_rdy) begin
                term_cnt <= '0;
            end else if (mac_en) begin
                term_cnt <= term_cnt + CNT_W'(1);
            end

            if (state != S_DRAIN && state_nx == S_DRAIN) begin
                drain_cnt <= DW'(MUL_LAT - 1);
            end else if (state == S_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DW'(1);
            end

            if (state != S_NORM && state_nx == S_NORM) begin
                norm_cnt <= NW'(NORM_CYC - 1);
            end else if (state == S_NORM && norm_cnt != '0) begin
                norm_cnt <= norm_cnt - NW'(1);
            end
        end
    end

    vld_delay_line #(
        .W(VLD_W)
    ) u_vld (
        .clk_i(clk_i),
        .rstn (rstn),
        .clr  (flush),
        .din  (mac_en),
        .q    (vld_d)
    );

endmodule

// File: tb/tb_mac_dot_seq_ctrl.sv
// Directed bench for mac_dot_seq_ctrl (K=9 lane plus a K=1 build).
module tb_mac_dot_seq_ctrl;

    logic clk_i = 1'b0;
    logic rstn  = 1'b1;
    always #5 clk_i = ~clk_i;

    logic        flush = 0, in_vld = 0, out_rdy = 0;
    logic        in_rdy, mac_en, acc_clr, acc_rdy, out_vld, busy;
    logic [11:0] vld_d;
    logic [3:0]  term_cnt;

    logic        flush1 = 0, in_vld1 = 0, out_rdy1 = 0;
    logic        in_rdy1, mac_en1, acc_clr1, acc_rdy1, out_vld1, busy1;
    logic [11:0] vld_d1;
    logic [0:0]  term_cnt1;

    int n_run  = 0;
    int n_fail = 0;

    mac_dot_seq_ctrl u_dut (
        .clk_i(clk_i), .rstn(rstn), .flush(flush),
        .in_vld(in_vld), .in_rdy(in_rdy), .out_rdy(out_rdy),
        .mac_en(mac_en), .acc_clr(acc_clr), .vld_d(vld_d),
        .acc_rdy(acc_rdy), .out_vld(out_vld), .busy(busy),
        .term_cnt(term_cnt)
    );

    mac_dot_seq_ctrl #(.K(1)) u_k1 (
        .clk_i(clk_i), .rstn(rstn), .flush(flush1),
        .in_vld(in_vld1), .in_rdy(in_rdy1), .out_rdy(out_rdy1),
        .mac_en(mac_en1), .acc_clr(acc_clr1), .vld_d(vld_d1),
        .acc_rdy(acc_rdy1), .out_vld(out_vld1), .busy(busy1),
        .term_cnt(term_cnt1)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #2;
        n_run++;
        if ({busy, acc_rdy, out_vld} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_flags got=%b exp=000",
                     {busy, acc_rdy, out_vld});
        end
        n_run++;
        if (term_cnt !== 4'd0 || vld_d !== 12'd0) begin
            n_fail++;
            $display("FAIL rst_cnt got=%0d/%h exp=0/000", term_cnt, vld_d);
        end
        n_run++;
        if (in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_rdy got=%b exp=1", in_rdy);
        end
        @(posedge clk_i);
        #3 rstn = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t <= 20; t++) begin
            in_vld  = (t < 9);
            out_rdy = 1'b1;
            #3;
            n_run++;
            if (mac_en !== (t < 9)) begin
                n_fail++;
                $display("FAIL b2b_mac_en c=%0d got=%b exp=%b",
                         t, mac_en, t < 9);
            end
            n_run++;
            if (acc_clr !== (t == 0)) begin
                n_fail++;
                $display("FAIL b2b_acc_clr c=%0d got=%b exp=%b",
                         t, acc_clr, t == 0);
            end
            n_run++;
            if (acc_rdy !== (t >= 14 && t <= 16)) begin
                n_fail++;
                $display("FAIL b2b_acc_rdy c=%0d got=%b", t, acc_rdy);
            end
            n_run++;
            if (out_vld !== (t == 17)) begin
                n_fail++;
                $display("FAIL b2b_out_vld c=%0d got=%b", t, out_vld);
            end
            if (t == 5) begin
                n_run++;
                if (vld_d !== 12'h01f) begin
                    n_fail++;
                    $display("FAIL b2b_vld_d got=%h exp=01f", vld_d);
                end
            end
            if (t == 9) begin
                n_run++;
                if (term_cnt !== 4'd9 || in_rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_full got=%0d/%b exp=9/0",
                             term_cnt, in_rdy);
                end
            end
            if (t == 20) begin
                n_run++;
                if (busy !== 1'b0 || term_cnt !== 4'd0) begin
                    n_fail++;
                    $display("FAIL b2b_idle got=%b/%0d exp=0/0",
                             busy, term_cnt);
                end
            end
            tick();
        end
        in_vld = 1'b0;
    endtask

    task automatic test_gaps();
        logic [31:0] m;
        int          exp_cnt;
        m       = 32'h0000_9d8d;
        exp_cnt = 0;
        for (int t = 0; t <= 26; t++) begin
            in_vld  = m[t];
            out_rdy = 1'b1;
            #3;
            n_run++;
            if (mac_en !== m[t]) begin
                n_fail++;
                $display("FAIL gap_mac_en c=%0d got=%b exp=%b",
                         t, mac_en, m[t]);
            end
            n_run++;
            if (term_cnt !== 4'(exp_cnt)) begin
                n_fail++;
                $display("FAIL gap_cnt c=%0d got=%0d exp=%0d",
                         t, term_cnt, exp_cnt);
            end
            n_run++;
            if (acc_rdy !== (t >= 21 && t <= 23)) begin
                n_fail++;
                $display("FAIL gap_acc_rdy c=%0d got=%b", t, acc_rdy);
            end
            n_run++;
            if (out_vld !== (t == 24)) begin
                n_fail++;
                $display("FAIL gap_out_vld c=%0d got=%b", t, out_vld);
            end
            if (m[t]) exp_cnt++;
            if (t == 24) exp_cnt = 0;
            tick();
        end
        in_vld = 1'b0;
    endtask

    task automatic test_out_stall();
        for (int t = 0; t <= 25; t++) begin
            in_vld  = (t < 9) || (t >= 17 && t <= 24);
            out_rdy = (t == 22);
            flush   = (t == 24);
            #3;
            if (t >= 17 && t <= 21) begin
                n_run++;
                if ({out_vld, in_rdy, mac_en} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL stall_hold c=%0d got=%b exp=100",
                             t, {out_vld, in_rdy, mac_en});
                end
                n_run++;
                if (term_cnt !== 4'd9) begin
                    n_fail++;
                    $display("FAIL stall_cnt c=%0d got=%0d exp=9",
                             t, term_cnt);
                end
            end
            if (t == 22) begin
                n_run++;
                if (out_vld !== 1'b1 || mac_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hs got=%b/%b exp=1/0",
                             out_vld, mac_en);
                end
            end
            if (t == 23) begin
                n_run++;
                if (mac_en !== 1'b1 || acc_clr !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_next got=%b/%b exp=1/1",
                             mac_en, acc_clr);
                end
            end
            if (t == 24) begin
                n_run++;
                if (mac_en !== 1'b0 || acc_clr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_gate got=%b/%b exp=0/0",
                             mac_en, acc_clr);
                end
            end
            if (t == 25) begin
                n_run++;
                if (busy !== 1'b0 || term_cnt !== 4'd0) begin
                    n_fail++;
                    $display("FAIL flush_idle got=%b/%0d exp=0/0",
                             busy, term_cnt);
                end
            end
            tick();
        end
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic test_flush();
        for (int t = 0; t <= 25; t++) begin
            in_vld  = (t < 9);
            out_rdy = 1'b1;
            flush   = (t == 15);
            #3;
            n_run++;
            if (out_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL fl_out_vld c=%0d got=%b exp=0", t, out_vld);
            end
            if (t == 15) begin
                n_run++;
                if (acc_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fl_norm got=%b exp=1", acc_rdy);
                end
            end
            if (t == 16) begin
                n_run++;
                if ({busy, acc_rdy} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL fl_state got=%b exp=00", {busy, acc_rdy});
                end
                n_run++;
                if (vld_d !== 12'd0 || term_cnt !== 4'd0) begin
                    n_fail++;
                    $display("FAIL fl_clr got=%h/%0d exp=000/0",
                             vld_d, term_cnt);
                end
            end
            tick();
        end
        in_vld = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 4; t++) begin
            in_vld = 1'b1;
            tick();
        end
        in_vld = 1'b0;
        #3;
        n_run++;
        if (term_cnt !== 4'd4 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_pre got=%0d/%b exp=4/1", term_cnt, busy);
        end
        rstn = 1'b0;
        #1;
        n_run++;
        if ({busy, acc_rdy, out_vld} !== 3'b000 || term_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL rm_async got=%b/%0d exp=000/0",
                     {busy, acc_rdy, out_vld}, term_cnt);
        end
        n_run++;
        if (vld_d !== 12'd0) begin
            n_fail++;
            $display("FAIL rm_vld_d got=%h exp=000", vld_d);
        end
        tick();
        #3 rstn = 1'b1;
        tick();
        in_vld = 1'b1;
        #3;
        n_run++;
        if (mac_en !== 1'b1 || acc_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_restart got=%b/%b exp=1/1", mac_en, acc_clr);
        end
        tick();
        in_vld = 1'b0;
        #3;
        n_run++;
        if (term_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL rm_cnt got=%0d exp=1", term_cnt);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic test_k1();
        for (int t = 0; t <= 11; t++) begin
            in_vld1  = (t == 0);
            out_rdy1 = 1'b1;
            #3;
            n_run++;
            if (mac_en1 !== (t == 0) || acc_clr1 !== (t == 0)) begin
                n_fail++;
                $display("FAIL k1_accept c=%0d got=%b/%b",
                         t, mac_en1, acc_clr1);
            end
            n_run++;
            if (acc_rdy1 !== (t >= 6 && t <= 8)) begin
                n_fail++;
                $display("FAIL k1_acc_rdy c=%0d got=%b", t, acc_rdy1);
            end
            n_run++;
            if (out_vld1 !== (t == 9)) begin
                n_fail++;
                $display("FAIL k1_out_vld c=%0d got=%b", t, out_vld1);
            end
            if (t == 1) begin
                n_run++;
                if ({in_rdy1, busy1, term_cnt1} !== 3'b011) begin
                    n_fail++;
                    $display("FAIL k1_drain got=%b exp=011",
                             {in_rdy1, busy1, term_cnt1});
                end
            end
            tick();
        end
        in_vld1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_out_stall();
        test_flush();
        test_reset_mid();
        test_k1();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
